// File: rtl/ila_slave_read_pkg.sv
// Shared AXI slave model definitions: widths, instruction indices, burst/resp codes.
package ila_slave_read_pkg;

    localparam int ID_W    = 12;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 8;
    localparam int N_INSTR = 6;

    // Instruction indices into grant / acc_decode
    localparam int I_R_RESET   = 0;
    localparam int I_AR_WAIT   = 1;
    localparam int I_AR_COMMIT = 2;
    localparam int I_R_LOAD    = 3;
    localparam int I_R_BEAT    = 4;
    localparam int I_R_LAST    = 5;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Next beat address: INCR steps to the next word boundary, FIXED and WRAP hold.
    function automatic logic [ADDR_W-1:0] axi_next_addr(input logic [ADDR_W-1:0] addr,
                                                        input logic [1:0]        burst);
        if (burst == BURST_INCR)
            return {addr[ADDR_W-1:2] + 30'd1, 2'b00};
        else
            return addr;
    endfunction

endpackage

// File: rtl/ila_slave_read.sv
// AXI4 slave read channel (AR/R) in ILA instruction/decode/grant form.
module ila_slave_read
    import ila_slave_read_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_INSTR-1:0]   __ILA_ILA_Slave_read_grant__,
    input  logic                 s_axi_aresetn,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic [1:0]           s_axi_arburst,
    input  logic [ID_W-1:0]      s_axi_arid,
    input  logic [LEN_W-1:0]     s_axi_arlen,
    input  logic [2:0]           s_axi_arsize,
    input  logic                 s_axi_arvalid,
    input  logic                 s_axi_rready,
    input  logic                 read_ready,
    input  logic [DATA_W-1:0]    read_data,
    output logic                 s_axi_arready,
    output logic [ID_W-1:0]      s_axi_rid,
    output logic [DATA_W-1:0]    s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rlast,
    output logic                 s_axi_rvalid,
    output logic                 tx_ractive,
    output logic [LEN_W-1:0]     tx_arlen,
    output logic [ADDR_W-1:0]    tx_araddr,
    output logic [1:0]           tx_arburst,
    output logic [2:0]           tx_arsize,
    output logic                 __ILA_ILA_Slave_read_decode_of_R_Slave_Reset__,
    output logic                 __ILA_ILA_Slave_read_decode_of_AR_Slave_Wait__,
    output logic                 __ILA_ILA_Slave_read_decode_of_AR_Slave_Commit__,
    output logic                 __ILA_ILA_Slave_read_decode_of_R_Slave_Load__,
    output logic                 __ILA_ILA_Slave_read_decode_of_R_Slave_Beat__,
    output logic                 __ILA_ILA_Slave_read_decode_of_R_Slave_Last__,
    output logic [N_INSTR-1:0]   __ILA_ILA_Slave_read_acc_decode__,
    output logic                 __ILA_ILA_Slave_read_valid__
);

    logic [N_INSTR-1:0] dec;
    logic [N_INSTR-1:0] en;

    // Instruction decodes; mutually exclusive by construction
    always_comb begin
        dec              = '0;
        dec[I_R_RESET]   = !s_axi_aresetn;
        dec[I_AR_WAIT]   = s_axi_aresetn && !tx_ractive && !s_axi_arready;
        dec[I_AR_COMMIT] = s_axi_aresetn && !tx_ractive && s_axi_arready && s_axi_arvalid;
        dec[I_R_LOAD]    = s_axi_aresetn && tx_ractive && !s_axi_rvalid && read_ready;
        dec[I_R_BEAT]    = s_axi_aresetn && tx_ractive && s_axi_rvalid && s_axi_rready && !s_axi_rlast;
        dec[I_R_LAST]    = s_axi_aresetn && tx_ractive && s_axi_rvalid && s_axi_rready && s_axi_rlast;
    end

    assign en = dec & __ILA_ILA_Slave_read_grant__;

    assign __ILA_ILA_Slave_read_decode_of_R_Slave_Reset__   = dec[I_R_RESET];
    assign __ILA_ILA_Slave_read_decode_of_AR_Slave_Wait__   = dec[I_AR_WAIT];
    assign __ILA_ILA_Slave_read_decode_of_AR_Slave_Commit__ = dec[I_AR_COMMIT];
    assign __ILA_ILA_Slave_read_decode_of_R_Slave_Load__    = dec[I_R_LOAD];
    assign __ILA_ILA_Slave_read_decode_of_R_Slave_Beat__    = dec[I_R_BEAT];
    assign __ILA_ILA_Slave_read_decode_of_R_Slave_Last__    = dec[I_R_LAST];
    assign __ILA_ILA_Slave_read_acc_decode__                = dec;
    assign __ILA_ILA_Slave_read_valid__                     = 1'b1;

    // Apply the granted instruction's updates; rst and protocol reset share one path
    always_ff @(posedge clk) begin
        if (rst || en[I_R_RESET]) begin
            s_axi_arready <= 1'b1;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
            s_axi_rlast   <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            tx_ractive    <= 1'b0;
            tx_arlen      <= '0;
            tx_araddr     <= '0;
            tx_arburst    <= '0;
            tx_arsize     <= '0;
        end else begin
            if (en[I_AR_WAIT])
                s_axi_arready <= 1'b1;
            if (en[I_AR_COMMIT]) begin
                s_axi_arready <= 1'b0;
                tx_ractive    <= 1'b1;
                s_axi_rid     <= s_axi_arid;
                tx_arlen      <= s_axi_arlen;
                tx_araddr     <= s_axi_araddr;
                tx_arburst    <= s_axi_arburst;
                tx_arsize     <= s_axi_arsize;
            end
            if (en[I_R_LOAD]) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= read_data;
                s_axi_rresp  <= RESP_OKAY;
                s_axi_rlast  <= (tx_arlen == '0);
            end
            if (en[I_R_BEAT]) begin
                s_axi_rvalid <= 1'b0;
                tx_arlen     <= tx_arlen - 8'd1;
                tx_araddr    <= axi_next_addr(tx_araddr, tx_arburst);
            end
            if (en[I_R_LAST]) begin
                s_axi_rvalid <= 1'b0;
                s_axi_rlast  <= 1'b0;
                tx_ractive   <= 1'b0;
            end
        end
    end

endmodule
